// File: rtl/mb_point_test_pattern_comparator.sv
// Receive-side mainband pattern comparator: regenerates the LFSR or per-lane-ID
// stream, counts per-lane bit errors and reports a registered pass/fail vector.
module mb_point_test_pattern_comparator #(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned ERR_W     = 12,
  parameter logic [22:0] LFSR_SEED = 23'h1DBFBC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           i_mainband_pattern_compartor_cw,
  input  logic                 i_comparison_valid_en,
  input  logic                 i_rx_valid,
  input  logic [NUM_LANES-1:0] i_rx_bits,
  input  logic [ERR_W-1:0]     i_error_threshold,
  output logic [15:0]          o_comparison_results,
  output logic                 o_results_valid,
  output logic                 o_any_error
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_COMPARE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  localparam logic [1:0]       CW_IDLE  = 2'b00;
  localparam logic [1:0]       CW_CLEAR = 2'b01;
  localparam logic [ERR_W-1:0] CNT_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] CNT_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]      RES_MASK = 16'((32'd1 << NUM_LANES) - 32'd1);

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [22:0]            lfsr_q, lfsr_d;
  logic [3:0]             idx_q, idx_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [NUM_LANES-1:0]   s1_rx_q, s1_rx_d;
  logic [NUM_LANES-1:0]   s1_exp_q, s1_exp_d;
  logic [ERR_W-1:0]       cnt_q [NUM_LANES];
  logic [ERR_W-1:0]       cnt_d [NUM_LANES];
  logic [15:0]            results_q, results_d;
  logic                   res_valid_q, res_valid_d;
  logic                   any_err_q, any_err_d;
  logic [NUM_LANES-1:0]   exp_bits;
  logic                   lfsr_fb;
  logic                   accept;

  // Lane n transmits {1010, n[7:0], 1010} MSB first.
  function automatic logic id_bit(input logic [7:0] lane, input logic [3:0] idx);
    logic [15:0] word;
    word = {4'hA, lane, 4'hA};
    return word[4'd15 - idx];
  endfunction

  assign lfsr_fb = lfsr_q[22] ^ lfsr_q[20] ^ lfsr_q[15] ^ lfsr_q[7] ^ lfsr_q[4] ^ lfsr_q[1];
  assign accept  = (state_q == ST_COMPARE) && i_comparison_valid_en && i_rx_valid &&
                   i_mainband_pattern_compartor_cw[1];

  // Control FSM next-state and compare-mode latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (i_mainband_pattern_compartor_cw == CW_CLEAR) begin
          state_d = ST_CLEAR;
        end else if (i_mainband_pattern_compartor_cw[1] && i_comparison_valid_en) begin
          state_d = ST_COMPARE;
          mode_d  = i_mainband_pattern_compartor_cw[0];
        end else begin
          state_d = state_q;
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_COMPARE: begin
        if (i_mainband_pattern_compartor_cw == CW_CLEAR) begin
          state_d = ST_CLEAR;
        end else if (!i_comparison_valid_en || (i_mainband_pattern_compartor_cw == CW_IDLE)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_COMPARE;
        end
      end
      ST_DRAIN: state_d = ST_HOLD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pattern generators, two-stage compare pipeline, counters and result capture.
  always_comb begin
    lfsr_d      = lfsr_q;
    idx_d       = idx_q;
    s1_valid_d  = 1'b0;
    s1_rx_d     = s1_rx_q;
    s1_exp_d    = s1_exp_q;
    cnt_d       = cnt_q;
    results_d   = results_q;
    res_valid_d = (state_d == ST_HOLD);
    any_err_d   = 1'b0;
    for (int n = 0; n < NUM_LANES; n++) begin
      exp_bits[n] = mode_q ? id_bit(8'(n), idx_q) : lfsr_q[22];
    end

    // Entering CLEAR wipes counters and drops any beat still in stage 1.
    if (state_d == ST_CLEAR) begin
      lfsr_d = LFSR_SEED;
      idx_d  = 4'd0;
      for (int n = 0; n < NUM_LANES; n++) begin
        cnt_d[n] = {ERR_W{1'b0}};
      end
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_rx_d    = i_rx_bits;
        s1_exp_d   = exp_bits;
        if (mode_q) begin
          idx_d = idx_q + 4'd1;
        end else begin
          lfsr_d = {lfsr_q[21:0], lfsr_fb};
        end
      end else begin
        s1_valid_d = 1'b0;
      end
      if (s1_valid_q) begin
        for (int n = 0; n < NUM_LANES; n++) begin
          if ((s1_rx_q[n] ^ s1_exp_q[n]) && (cnt_q[n] != CNT_MAX)) begin
            cnt_d[n] = cnt_q[n] + CNT_ONE;
          end else begin
            cnt_d[n] = cnt_q[n];
          end
        end
      end else begin
        cnt_d = cnt_q;
      end
    end

    for (int n = 0; n < NUM_LANES; n++) begin
      any_err_d = any_err_d | (cnt_d[n] != {ERR_W{1'b0}});
    end

    if (state_q == ST_DRAIN) begin
      results_d = 16'h0000;
      for (int n = 0; n < NUM_LANES; n++) begin
        results_d[n] = (cnt_q[n] <= i_error_threshold);
      end
    end else begin
      results_d = results_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      idx_q       <= 4'd0;
      s1_valid_q  <= 1'b0;
      s1_rx_q     <= {NUM_LANES{1'b0}};
      s1_exp_q    <= {NUM_LANES{1'b0}};
      for (int n = 0; n < NUM_LANES; n++) begin
        cnt_q[n] <= {ERR_W{1'b0}};
      end
      results_q   <= RES_MASK;
      res_valid_q <= 1'b0;
      any_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_rx_q     <= s1_rx_d;
      s1_exp_q    <= s1_exp_d;
      cnt_q       <= cnt_d;
      results_q   <= results_d;
      res_valid_q <= res_valid_d;
      any_err_q   <= any_err_d;
    end
  end

  assign o_comparison_results = results_q;
  assign o_results_valid      = res_valid_q;
  assign o_any_error          = any_err_q;

endmodule
